// File: rtl/spi_shifter.sv
// SPI mode-0 byte shifter with divided SPI clock, deferred chip-select updates and overrun flag.
// Optional SPI_TXHOLD_EN adds a one-byte transmit holding register for back-to-back bytes.
module spi_shifter #(
    parameter int DIV_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [DIV_W-1:0] DIV,
    input  logic             WR_STB,
    input  logic [7:0]       WR_DATA,
    input  logic             CS_WR,
    input  logic [1:0]       CS_DATA,
    input  logic             RD_STB,
    output logic [7:0]       RD_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVR,
    output logic             SPI_CLK,
    output logic             SPI_MOSI,
    input  logic             SPI_MISO,
    output logic [1:0]       SPI_CS
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_s;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_s;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_s;
    logic [7:0]       tx_sr_r;
    logic [7:0]       tx_sr_s;
    logic [7:0]       rx_sr_r;
    logic [7:0]       rx_sr_s;
    logic [7:0]       rd_data_r;
    logic [7:0]       rd_data_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic             ovr_r;
    logic             ovr_s;
    logic             spi_clk_r;
    logic             spi_clk_s;
    logic             mosi_r;
    logic             mosi_s;
    logic [1:0]       cs_r;
    logic [1:0]       cs_s;
    logic             cs_pend_r;
    logic             cs_pend_s;
    logic [1:0]       cs_pend_val_r;
    logic [1:0]       cs_pend_val_s;

    logic             phase_end_s;
    logic             last_bit_s;
    logic             end_s;
    logic             chain_s;
    logic             drop_s;
    logic [7:0]       start_data_s;

    assign phase_end_s = (cnt_r == div_r);
    assign last_bit_s  = (bit_cnt_r == 3'd7);
    assign end_s       = (state_r == HIGH) && phase_end_s && last_bit_s;

`ifdef SPI_TXHOLD_EN
    logic       hold_valid_r;
    logic [7:0] hold_data_r;
    logic       store_s;

    // A write while busy fills the holding slot; at end-of-byte the slot frees on that same edge.
    assign store_s      = WR_STB && (state_r != IDLE) && (end_s ? hold_valid_r : !hold_valid_r);
    assign chain_s      = end_s && (hold_valid_r || WR_STB);
    assign drop_s       = WR_STB && (state_r != IDLE) && hold_valid_r && !end_s;
    assign start_data_s = hold_valid_r ? hold_data_r : WR_DATA;

    // Holding register: filled by writes during a transfer, emptied when its byte starts.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= 8'hFF;
        end else if (store_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= WR_DATA;
        end else if (end_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end
`else
    assign chain_s      = 1'b0;
    assign drop_s       = WR_STB && (state_r != IDLE);
    assign start_data_s = WR_DATA;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: each SPI_CLK phase lasts DIV+1 cycles of the latched divider.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (WR_STB) state_s = LOW;
                else        state_s = IDLE;
            end
            LOW: begin
                if (phase_end_s) state_s = HIGH;
                else             state_s = LOW;
            end
            HIGH: begin
                if (!phase_end_s)    state_s = HIGH;
                else if (!last_bit_s) state_s = LOW;
                else if (chain_s)     state_s = LOW;
                else                  state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output/datapath next values; loading a byte happens from IDLE or chained at end-of-byte.
    always_comb begin
        div_s     = div_r;
        cnt_s     = cnt_r;
        bit_cnt_s = bit_cnt_r;
        tx_sr_s   = tx_sr_r;
        rx_sr_s   = rx_sr_r;
        rd_data_s = rd_data_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        spi_clk_s = spi_clk_r;
        mosi_s    = mosi_r;
        case (state_r)
            IDLE: begin
                cnt_s     = {DIV_W{1'b0}};
                spi_clk_s = 1'b0;
                if (WR_STB) begin
                    div_s     = DIV;
                    bit_cnt_s = 3'd0;
                    mosi_s    = start_data_s[7];
                    tx_sr_s   = {start_data_s[6:0], 1'b1};
                    busy_s    = 1'b1;
                end else begin
                    mosi_s    = 1'b1;
                    busy_s    = 1'b0;
                end
            end
            LOW: begin
                if (phase_end_s) begin
                    cnt_s     = {DIV_W{1'b0}};
                    spi_clk_s = 1'b1;
                    rx_sr_s   = {rx_sr_r[6:0], SPI_MISO};
                end else begin
                    cnt_s     = cnt_r + DIV_W'(1);
                end
            end
            HIGH: begin
                if (!phase_end_s) begin
                    cnt_s     = cnt_r + DIV_W'(1);
                end else if (!last_bit_s) begin
                    cnt_s     = {DIV_W{1'b0}};
                    spi_clk_s = 1'b0;
                    mosi_s    = tx_sr_r[7];
                    tx_sr_s   = {tx_sr_r[6:0], 1'b1};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                end else begin
                    cnt_s     = {DIV_W{1'b0}};
                    spi_clk_s = 1'b0;
                    rd_data_s = rx_sr_r;
                    done_s    = 1'b1;
                    if (chain_s) begin
                        div_s     = DIV;
                        bit_cnt_s = 3'd0;
                        mosi_s    = start_data_s[7];
                        tx_sr_s   = {start_data_s[6:0], 1'b1};
                        busy_s    = 1'b1;
                    end else begin
                        mosi_s    = 1'b1;
                        busy_s    = 1'b0;
                    end
                end
            end
            default: begin
                cnt_s     = {DIV_W{1'b0}};
                spi_clk_s = 1'b0;
                mosi_s    = 1'b1;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Chip-select and overrun next values; a CS write during a transfer waits for end-of-byte.
    always_comb begin
        cs_s          = cs_r;
        cs_pend_s     = cs_pend_r;
        cs_pend_val_s = cs_pend_val_r;
        ovr_s         = ovr_r;
        if (state_r == IDLE) begin
            cs_pend_s = 1'b0;
            if (CS_WR) cs_s = CS_DATA;
            else       cs_s = cs_r;
        end else if (end_s) begin
            cs_pend_s = 1'b0;
            if (CS_WR)          cs_s = CS_DATA;
            else if (cs_pend_r) cs_s = cs_pend_val_r;
            else                cs_s = cs_r;
        end else if (CS_WR) begin
            cs_pend_s     = 1'b1;
            cs_pend_val_s = CS_DATA;
        end else begin
            cs_pend_s     = cs_pend_r;
        end
        if (drop_s)      ovr_s = 1'b1;
        else if (RD_STB) ovr_s = 1'b0;
        else             ovr_s = ovr_r;
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_r         <= {DIV_W{1'b0}};
            cnt_r         <= {DIV_W{1'b0}};
            bit_cnt_r     <= 3'd0;
            tx_sr_r       <= 8'hFF;
            rx_sr_r       <= 8'hFF;
            rd_data_r     <= 8'hFF;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ovr_r         <= 1'b0;
            spi_clk_r     <= 1'b0;
            mosi_r        <= 1'b1;
            cs_r          <= 2'b11;
            cs_pend_r     <= 1'b0;
            cs_pend_val_r <= 2'b11;
        end else begin
            div_r         <= div_s;
            cnt_r         <= cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            tx_sr_r       <= tx_sr_s;
            rx_sr_r       <= rx_sr_s;
            rd_data_r     <= rd_data_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            ovr_r         <= ovr_s;
            spi_clk_r     <= spi_clk_s;
            mosi_r        <= mosi_s;
            cs_r          <= cs_s;
            cs_pend_r     <= cs_pend_s;
            cs_pend_val_r <= cs_pend_val_s;
        end
    end

    assign RD_DATA  = rd_data_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;
    assign OVR      = ovr_r;
    assign SPI_CLK  = spi_clk_r;
    assign SPI_MOSI = mosi_r;
    assign SPI_CS   = cs_r;

endmodule

// File: doc/spi_shifter.md
SPI_SHIFTER -- requirements
Module: spi_shifter

Interface
REQ-001 SHALL have parameter DIV_W, default 4: width of the clock divider value.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DIV  input  DIV_W  SPI half-period in CLK cycles, minus 1.
REQ-005 SHALL have port WR_STB  input  1  one-cycle strobe from bus decode: load byte, start transfer.
REQ-006 SHALL have port WR_DATA  input  8  transmit byte, MSB first.
REQ-007 SHALL have port CS_WR  input  1  one-cycle strobe: update chip selects.
REQ-008 SHALL have port CS_DATA  input  2  new chip-select value, active-low.
REQ-009 SHALL have port RD_STB  input  1  one-cycle strobe: CPU read of RD_DATA/status, clears OVR.
REQ-010 SHALL have port RD_DATA  output  8  last received byte.
REQ-011 SHALL have port BUSY  output  1  transfer in progress.
REQ-012 SHALL have port DONE  output  1  one-cycle pulse at end of each byte.
REQ-013 SHALL have port OVR  output  1  sticky: a write was dropped.
REQ-014 SHALL have ports SPI_CLK output 1, SPI_MOSI output 1, SPI_MISO input 1, SPI_CS output 2 (active-low).

Function
REQ-015 SHALL implement SPI mode 0: SPI_CLK idles low, MOSI changes on falling edge/start, MISO sampled on rising edge.
REQ-016 SHALL use states IDLE, LOW, HIGH; IDLE->LOW on accepted WR_STB; LOW->HIGH and HIGH->LOW after DIV+1 CLK cycles each.
REQ-017 SHALL latch DIV at transfer start; changes to DIV mid-byte SHALL NOT affect the current byte.
REQ-018 SHALL drive SPI_MOSI = WR_DATA[7] in the cycle after WR_STB, then next bit at each falling SPI_CLK edge.
REQ-019 SHALL shift SPI_MISO into the receive register LSB-first-in at each rising SPI_CLK edge (first bit ends as bit 7).
REQ-020 SHALL take exactly 16*(DIV+1) CLK cycles per byte, BUSY high throughout; after the 8th HIGH phase SPI_CLK returns low.
REQ-021 SHALL, on the cycle the 8th HIGH phase ends, update RD_DATA, pulse DONE for one cycle, deassert BUSY (unless a chained byte starts, see REQ-029), return to IDLE.
REQ-022 SHALL drive SPI_MOSI high in IDLE.
REQ-023 SHALL apply CS_WR in IDLE on the same edge; CS_WR while BUSY SHALL be held pending and applied on the DONE cycle; a later CS_WR overwrites a pending one.
REQ-024 SHALL, for simultaneous CS_WR and WR_STB in IDLE, apply CS first on that edge and start the transfer on the same edge.
REQ-025 SHALL set OVR when WR_STB arrives and the byte cannot be accepted; RD_STB clears OVR; set wins over simultaneous clear.
REQ-026 SHALL leave RD_DATA unchanged by RD_STB; RD_STB has no effect on the transfer.

Reset
REQ-027 SHALL, while RESET low, force state IDLE, SPI_CLK=0, SPI_MOSI=1, SPI_CS=2'b11, RD_DATA=8'hFF, BUSY=0, DONE=0, OVR=0, no pending CS or byte; a transfer in progress is abandoned with no DONE.

Configuration
REQ-028 SHALL, without SPI_TXHOLD_EN defined, ignore WR_STB while BUSY and set OVR.
REQ-029 SHALL, with SPI_TXHOLD_EN defined, provide a one-byte holding register: WR_STB while BUSY and holding empty stores the byte; on DONE the held byte starts on the same edge (BUSY stays high, no idle cycle); WR_STB with holding full is dropped and sets OVR; pending CS is applied before the held byte starts.

Verification
REQ-030 SHALL cover: DIV=0, WR_STB with 8'hA5, MISO loopback from MOSI -> 16-cycle BUSY, 8 SPI_CLK pulses, DONE once, RD_DATA=8'hA5.
REQ-031 SHALL cover: DIV=3, WR 8'h3C, MISO tied 0 -> BUSY 64 cycles, SPI_CLK half-period 4 cycles, RD_DATA=8'h00.
REQ-032 SHALL cover: CS_WR 2'b10 mid-byte -> SPI_CS stays 2'b11 until DONE cycle, then 2'b10.
REQ-033 SHALL cover: second WR_STB mid-byte -> without macro OVR=1 and one byte sent; with SPI_TXHOLD_EN two back-to-back bytes, two DONE pulses, OVR=0.
REQ-034 SHALL cover: RESET low during bit 4 -> SPI_CLK=0, MOSI=1, CS=2'b11, RD_DATA=8'hFF, no DONE.
REQ-035 SHALL cover: OVR set, RD_STB -> OVR=0; OVR set and RD_STB same cycle -> OVR=1.
